// File: rtl/fetch_if_id.sv
//==============================================================================
// Module      : fetch_if_id
// Description : MIPS fetch stage (PC, AdEL detection) plus IF/ID register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_if_id #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IM_END    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        npc_sel,
    input  logic [31:0] npc_target,
    input  logic        is_branch_D,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic        bd_D,
    output logic [4:0]  exccode_D,
    output logic        valid_D
);

    localparam logic [4:0] c_EXC_NONE = 5'd0;
    localparam logic [4:0] c_EXC_ADEL = 5'd4;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc8_d;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic        r_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_plus8;
    logic        w_adel;
    logic        w_flush;
    logic [31:0] w_pc_next;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_plus8 = r_pc + 32'd8;
    assign w_adel     = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_END);
    assign w_flush    = exc_req || eret_req;

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (exc_req)
            w_pc_next = EXC_ENTRY;
        else if (eret_req)
            w_pc_next = epc;
        else if (stall)
            w_pc_next = r_pc;
        else if (npc_sel)
            w_pc_next = npc_target;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_pc <= PC_RESET;
        else
            r_pc <= w_pc_next;
    end

    // Flush beats stall: the instruction in F is discarded on exception/eret entry.
    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_instr   <= 32'h0;
            r_pc_d    <= 32'h0;
            r_pc8_d   <= 32'h0;
            r_bd      <= 1'b0;
            r_exccode <= c_EXC_NONE;
            r_valid   <= 1'b0;
        end else if (!stall) begin
            r_pc_d    <= r_pc;
            r_pc8_d   <= w_pc_plus8;
            r_bd      <= is_branch_D;
            r_valid   <= 1'b1;
            // Faulting fetch becomes a nop carrying its PC so CP0 can log BadVAddr.
            r_instr   <= w_adel ? 32'h0 : imem_rdata;
            r_exccode <= w_adel ? c_EXC_ADEL : c_EXC_NONE;
        end
    end

    assign imem_addr = r_pc;
    assign instr_D   = r_instr;
    assign pc_D      = r_pc_d;
    assign pc8_D     = r_pc8_d;
    assign bd_D      = r_bd;
    assign exccode_D = r_exccode;
    assign valid_D   = r_valid;

endmodule

`default_nettype wire
